// File: rtl/pf_iod_dly_pkg.sv
// Shared definitions for the IOD delay-line sequencer.
// Contents: command op encodings, sequencer state enum, lane-index width helper.
package pf_iod_dly_pkg;

    typedef enum logic [1:0] {
        OP_INC   = 2'b00,
        OP_DEC   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_QUERY = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_SETTLE,
        ST_LOADP,
        ST_DONE
    } state_t;

    // Lane index width; a single-lane build still carries a 1-bit lane field.
    function automatic int unsigned lane_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pf_iod_dly_settle_timer.sv
// Loadable down-counter timing the settle gap after each MOVE/LOAD pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load the counter with 'load' (asserted the cycle before settle)
//   load       : settle length in cycles (>= 1)
//   done       : high in the last settle cycle
module pf_iod_dly_settle_timer #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CNT_W      = $clog2(SETTLE_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] load,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= load;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // First settle cycle holds 'load', last one holds 1.
    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pf_iod_dly_seq_ctrl.sv
// Sequencer for dynamic IOD delay lines. One shared engine runs one tap-adjust
// command at a time on a selected lane, spacing MOVE/LOAD pulses with a setup
// cycle and a settle gap, and stops early on DELAY_LINE_OUT_OF_RANGE.
// Ports:
//   FAB_CLK, ARST_N            : clock, asynchronous active-low reset
//   REQ_VALID/READY            : command handshake
//   REQ_LANE/OP/STEPS          : target lane, op (INC/DEC/LOAD/QUERY), tap count
//   RSP_VALID/LANE/TAP/OOR     : single-cycle completion report
//   DELAY_LINE_MOVE/LOAD       : one-hot per-lane pulses
//   DELAY_LINE_DIRECTION       : 1 = increment, shared by all lanes
//   DELAY_LINE_OUT_OF_RANGE    : per-lane range flag from the IODs
// Build option: PF_IOD_DLY_SHADOW_EN keeps an absolute tap shadow per lane
// and enables the 0/MAX_TAP limit checks; otherwise RSP_TAP reports taps moved.
module pf_iod_dly_seq_ctrl
    import pf_iod_dly_pkg::*;
#(
    parameter  int unsigned NUM_LANES  = 4,
    parameter  int unsigned TAP_W      = 7,
    parameter  int unsigned MAX_TAP    = 127,
    parameter  int unsigned LOAD_TAP   = 1,
    parameter  int unsigned SETTLE_CYC = 4,
    localparam int unsigned LANE_W     = lane_width(NUM_LANES)
) (
    input  logic                 FAB_CLK,
    input  logic                 ARST_N,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [LANE_W-1:0]    REQ_LANE,
    input  logic [1:0]           REQ_OP,
    input  logic [7:0]           REQ_STEPS,
    output logic                 RSP_VALID,
    output logic [LANE_W-1:0]    RSP_LANE,
    output logic [TAP_W-1:0]     RSP_TAP,
    output logic                 RSP_OOR,
    output logic [NUM_LANES-1:0] DELAY_LINE_MOVE,
    output logic                 DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0] DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0] DELAY_LINE_OUT_OF_RANGE
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

    state_t               state_q, state_d;
    logic [LANE_W-1:0]    lane_q;
    op_t                  op_q, req_op;
    logic [7:0]           rem_q;
    logic                 oor_q, dir_q;
    logic [NUM_LANES-1:0] lane_sel;
    logic                 accept, req_lane_ok, oor_in, at_limit, set_oor;
    logic                 timer_start, timer_done;
    logic [TAP_W-1:0]     cur_tap;

    assign req_op      = op_t'(REQ_OP);
    assign accept      = (state_q == ST_IDLE) && REQ_VALID;
    assign req_lane_ok = 32'(REQ_LANE) < NUM_LANES;
    assign lane_sel    = NUM_LANES'(1) << lane_q;
    assign oor_in      = |(DELAY_LINE_OUT_OF_RANGE & lane_sel);

`ifdef PF_IOD_DLY_SHADOW_EN
    logic [TAP_W-1:0] shadow_q [NUM_LANES];

    // An unmatched (out-of-range) lane reads as 0, which is what RSP_TAP reports.
    always_comb begin
        cur_tap = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_q == LANE_W'(i)) cur_tap = shadow_q[i];
        end
    end

    assign at_limit = (op_q == OP_INC) ? (cur_tap == TAP_W'(MAX_TAP)) : (cur_tap == '0);

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) shadow_q[i] <= TAP_W'(LOAD_TAP);
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (lane_q == LANE_W'(i)) begin
                    if (state_q == ST_PULSE) begin
                        shadow_q[i] <= (op_q == OP_INC) ? shadow_q[i] + 1'b1 : shadow_q[i] - 1'b1;
                    end else if (state_q == ST_LOADP) begin
                        shadow_q[i] <= TAP_W'(LOAD_TAP);
                    end
                end
            end
        end
    end
`else
    // Taps moved by the current command; a LOAD reports the known load value.
    logic [TAP_W-1:0] moved_q;

    assign cur_tap  = moved_q;
    assign at_limit = 1'b0;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            moved_q <= '0;
        end else if (accept) begin
            moved_q <= '0;
        end else if (state_q == ST_PULSE) begin
            moved_q <= moved_q + 1'b1;
        end else if (state_q == ST_LOADP) begin
            moved_q <= TAP_W'(LOAD_TAP);
        end
    end
`endif

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            op_q    <= OP_INC;
            rem_q   <= '0;
            oor_q   <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lane_q <= REQ_LANE;
                op_q   <= req_op;
                rem_q  <= REQ_STEPS;
                oor_q  <= !req_lane_ok;
                dir_q  <= (req_op == OP_INC);
            end else begin
                if (state_q == ST_PULSE) rem_q <= rem_q - 8'd1;
                if (set_oor)             oor_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_start = 1'b0;
        set_oor     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    if (!req_lane_ok || req_op == OP_QUERY ||
                        (req_op != OP_LOAD && REQ_STEPS == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (op_q == OP_LOAD) begin
                    state_d = ST_LOADP;
                end else if (at_limit) begin
                    set_oor = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE, ST_LOADP: begin
                timer_start = 1'b1;
                state_d     = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Range flag wins over completion; the shadow limit is only
                // checked before a further pulse would be issued.
                if (timer_done) begin
                    if (op_q == OP_LOAD) begin
                        state_d = ST_DONE;
                    end else if (oor_in) begin
                        set_oor = 1'b1;
                        state_d = ST_DONE;
                    end else if (rem_q == '0) begin
                        state_d = ST_DONE;
                    end else if (at_limit) begin
                        set_oor = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_PULSE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    pf_iod_dly_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) u_settle (
        .clk   (FAB_CLK),
        .rst_n (ARST_N),
        .start (timer_start),
        .load  (CNT_W'(SETTLE_CYC)),
        .done  (timer_done)
    );

    assign REQ_READY            = (state_q == ST_IDLE);
    assign DELAY_LINE_MOVE      = (state_q == ST_PULSE) ? lane_sel : '0;
    assign DELAY_LINE_LOAD      = (state_q == ST_LOADP) ? lane_sel : '0;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign RSP_VALID            = (state_q == ST_DONE);
    assign RSP_LANE             = RSP_VALID ? lane_q : '0;
    assign RSP_OOR              = RSP_VALID & oor_q;
    assign RSP_TAP              = RSP_VALID ? cur_tap : '0;

endmodule

// File: tb/tb_pf_iod_dly_seq_ctrl.sv
// Self-checking bench for pf_iod_dly_seq_ctrl: directed scenarios plus random
// commands compared against a per-command arithmetic reference model.
// Honours PF_IOD_DLY_SHADOW_EN the same way as the design.
module tb_pf_iod_dly_seq_ctrl;

    localparam int NL   = 4;
    localparam int MAXT = 127;
    localparam int LT   = 1;
    localparam int SC   = 4;
`ifdef PF_IOD_DLY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0, req_ready;
    logic [1:0] req_lane = '0, req_op = '0;
    logic [7:0] req_steps = '0;
    logic       rsp_valid, rsp_oor, dir;
    logic [1:0] rsp_lane;
    logic [6:0] rsp_tap;
    logic [3:0] move, load, oor_in = '0;

    // Three-lane instance: lane index 3 is representable but out of range.
    logic       v3 = 1'b0, ready3, rsp3_valid, rsp3_oor, dir3;
    logic [1:0] lane3 = '0, op3 = '0, rsp3_lane;
    logic [7:0] steps3 = '0;
    logic [6:0] rsp3_tap;
    logic [2:0] move3, load3, oor3 = '0;

    pf_iod_dly_seq_ctrl #(.NUM_LANES(NL), .TAP_W(7), .MAX_TAP(MAXT), .LOAD_TAP(LT), .SETTLE_CYC(SC)) u_dut (
        .FAB_CLK(clk), .ARST_N(rst_n), .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_LANE(req_lane), .REQ_OP(req_op), .REQ_STEPS(req_steps),
        .RSP_VALID(rsp_valid), .RSP_LANE(rsp_lane), .RSP_TAP(rsp_tap), .RSP_OOR(rsp_oor),
        .DELAY_LINE_MOVE(move), .DELAY_LINE_DIRECTION(dir), .DELAY_LINE_LOAD(load),
        .DELAY_LINE_OUT_OF_RANGE(oor_in));

    pf_iod_dly_seq_ctrl #(.NUM_LANES(3), .TAP_W(7), .MAX_TAP(MAXT), .LOAD_TAP(LT), .SETTLE_CYC(SC)) u_dut3 (
        .FAB_CLK(clk), .ARST_N(rst_n), .REQ_VALID(v3), .REQ_READY(ready3),
        .REQ_LANE(lane3), .REQ_OP(op3), .REQ_STEPS(steps3),
        .RSP_VALID(rsp3_valid), .RSP_LANE(rsp3_lane), .RSP_TAP(rsp3_tap), .RSP_OOR(rsp3_oor),
        .DELAY_LINE_MOVE(move3), .DELAY_LINE_DIRECTION(dir3), .DELAY_LINE_LOAD(load3),
        .DELAY_LINE_OUT_OF_RANGE(oor3));

    int n_checks = 0;
    int n_fail   = 0;
    int model_tap [NL];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) model_tap[i] = LT;
    endtask

    // Issue one command on the main DUT. k = pulse count after which the
    // lane's OUT_OF_RANGE flag is raised (large value = never).
    task automatic do_cmd(input string name, input int lane, input int op, input int steps, input int k);
        int e_lat, e_mv, e_ld, e_tap, e_oor, room, t, n;
        int cyc, mv, ld, stray, gap_err, dir_err, ready_err, last_pc;
        int g_lat, g_tap, g_oor, g_lane;
        logic [3:0] lmask;
        bit done;

        t = model_tap[lane];
        if (op == 3 || (op < 2 && steps == 0)) begin
            e_lat = 1; e_mv = 0; e_ld = 0; e_oor = 0;
            e_tap = SHADOW ? t : 0;
        end else if (op == 2) begin
            e_lat = 3 + SC; e_mv = 0; e_ld = 1; e_oor = 0;
            e_tap = LT; t = LT;
        end else begin
            room = !SHADOW ? 100000 : ((op == 0) ? MAXT - t : t);
            n = steps;
            if (room < n) n = room;
            if (k < n) n = k;
            e_oor = ((k <= steps && k <= room) || room < steps) ? 1 : 0;
            e_lat = 2 + n * (1 + SC);
            e_mv  = n; e_ld = 0;
            t     = (op == 0) ? t + n : t - n;
            e_tap = SHADOW ? t : n;
        end
        if (SHADOW) model_tap[lane] = t;

        lmask = 4'b0001 << lane;
        @(negedge clk);
        req_valid = 1'b1; req_lane = 2'(lane); req_op = 2'(op); req_steps = 8'(steps);
        oor_in = '0;
        cyc = 0;
        while (!req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) check_eq({name, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1; mv = 0; ld = 0; stray = 0; gap_err = 0; dir_err = 0; ready_err = 0; last_pc = 0;
        g_lat = -1; g_tap = -1; g_oor = -1; g_lane = -1;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            if ((move & load) != '0 || $countones(move | load) > 1) stray++;
            if ((move & ~lmask) != '0 || (load & ~lmask) != '0) stray++;
            if (cyc == 1 && op < 2 && steps > 0 && dir !== (op == 0)) dir_err++;
            if (move[lane]) begin
                mv++;
                if (mv == 1 && cyc != 2) gap_err++;
                if (mv > 1 && cyc - last_pc != 1 + SC) gap_err++;
                last_pc = cyc;
                if (dir !== (op == 0)) dir_err++;
                if (mv == k) oor_in[lane] = 1'b1;
            end
            if (load[lane]) begin
                ld++;
                if (cyc != 2) gap_err++;
            end
            if (req_ready) ready_err++;
            if (rsp_valid) begin
                done = 1'b1;
                g_lat = cyc; g_tap = int'(rsp_tap); g_oor = int'(rsp_oor); g_lane = int'(rsp_lane);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq({name, "_latency"}, g_lat, e_lat);
        check_eq({name, "_tap"}, g_tap, e_tap);
        check_eq({name, "_oor"}, g_oor, e_oor);
        check_eq({name, "_lane"}, g_lane, lane);
        check_eq({name, "_moves"}, mv, e_mv);
        check_eq({name, "_loads"}, ld, e_ld);
        check_eq({name, "_stray_pulse"}, stray, 0);
        check_eq({name, "_pulse_spacing"}, gap_err, 0);
        check_eq({name, "_direction"}, dir_err, 0);
        check_eq({name, "_busy_ready"}, ready_err, 0);
        @(negedge clk);
        oor_in = '0;
        check_eq({name, "_rsp_single"}, int'(rsp_valid), 0);
        check_eq({name, "_ready_after"}, int'(req_ready), 1);
    endtask

    initial begin
        int seen, rdy_bad;
        model_reset();

        // Reset state
        #12;
        check_eq("rst_ready", int'(req_ready), 1);
        check_eq("rst_rsp_valid", int'(rsp_valid), 0);
        check_eq("rst_pulses", int'({move, load}), 0);
        check_eq("rst_dir", int'(dir), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", int'(req_ready), 1);
        check_eq("post_rst_rsp_tap", int'(rsp_tap), 0);

        // Directed scenarios
        do_cmd("inc_l2_s3", 2, 0, 3, 1000);
        do_cmd("dec_l0_s5", 0, 1, 5, 1000);
        do_cmd("inc_l1_oor", 1, 0, 10, 2);
        do_cmd("inc_l3_s2", 3, 0, 2, 1000);
        do_cmd("load_l3", 3, 2, 0, 1000);
        do_cmd("query_l3", 3, 3, 0, 1000);
        do_cmd("inc_zero_steps", 1, 0, 0, 1000);

        // Back-to-back with REQ_VALID held high
        @(negedge clk);
        req_valid = 1'b1; req_lane = 2'd1; req_op = 2'd3; req_steps = 8'd0;
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b_rsp1", int'(rsp_valid), 1);
        check_eq("b2b_rsp1_tap", int'(rsp_tap), SHADOW ? model_tap[1] : 0);
        check_eq("b2b_busy", int'(req_ready), 0);
        @(negedge clk);
        check_eq("b2b_gap", int'(rsp_valid), 0);
        check_eq("b2b_ready", int'(req_ready), 1);
        @(negedge clk);
        check_eq("b2b_rsp2", int'(rsp_valid), 1);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_idle", int'(req_ready), 1);

        // Out-of-range lane on the three-lane instance
        @(negedge clk);
        v3 = 1'b1; lane3 = 2'd3; op3 = 2'd0; steps3 = 8'd2;
        @(posedge clk);
        @(negedge clk);
        v3 = 1'b0;
        check_eq("badlane_rsp", int'(rsp3_valid), 1);
        check_eq("badlane_oor", int'(rsp3_oor), 1);
        check_eq("badlane_tap", int'(rsp3_tap), 0);
        check_eq("badlane_lane", int'(rsp3_lane), 3);
        check_eq("badlane_pulses", int'({move3, load3}), 0);
        @(negedge clk);
        check_eq("badlane_ready", int'(ready3), 1);

        // Reset in the middle of a 4-step INC
        @(negedge clk);
        req_valid = 1'b1; req_lane = 2'd0; req_op = 2'd0; req_steps = 8'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("midrst_move_before", int'(move[0]), 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_move_async", int'(move), 0);
        check_eq("midrst_rsp", int'(rsp_valid), 0);
        seen = 0; rdy_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) seen++;
            if (!req_ready) rdy_bad++;
        end
        rst_n = 1'b1;
        model_reset();
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || move != '0) seen++;
            if (!req_ready) rdy_bad++;
        end
        check_eq("midrst_no_rsp", seen, 0);
        check_eq("midrst_ready", rdy_bad, 0);
        do_cmd("midrst_query", 0, 3, 0, 1000);

        // Random commands
        for (int i = 0; i < 40; i++) begin
            int lane, op, steps, k;
            lane  = $urandom_range(0, NL - 1);
            op    = $urandom_range(0, 3);
            steps = $urandom_range(0, 10);
            k     = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 1000;
            do_cmd($sformatf("rnd%0d", i), lane, op, steps, k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
